// File: rtl/cpu_types_pkg.sv
// Shared datapath types: bus word type plus the memory arbiter state and its default limits.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned ARB_MAX_DSTREAK = 3;
  localparam int unsigned ARB_TIMEOUT     = 64;

  typedef enum logic [1:0] {ARB_IDLE, ARB_IACC, ARB_DACC} arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access; data is favoured, with a
// bounded streak so that fetch cannot starve, and a watchdog that aborts unanswered accesses.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = ARB_MAX_DSTREAK,
  parameter int unsigned TIMEOUT     = ARB_TIMEOUT
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  ihit,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dhit,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ram_ack,
  output logic  ram_err
);

  localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  arb_state_t    state_q, state_d;
  word_t         addr_q, store_q;
  logic          wen_q;
  logic          abort_q;
  logic [SW-1:0] streak_q;
  logic [WW-1:0] wdog_q;
  logic          err_q;

  logic busy, d_req, d_grant, fetch_stale, wdog_expire;

  assign busy        = (state_q != ARB_IDLE);
  assign d_req       = dREN | dWEN;
  assign d_grant     = d_req && (!iREN || (streak_q < SW'(MAX_DSTREAK)));
  // Fetch is stale once the PC drops or redirects away from the address being fetched.
  assign fetch_stale = !iREN || (iaddr != addr_q);
  assign wdog_expire = busy && !ram_ack && (wdog_q == WW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (d_grant) begin
          state_d = ARB_DACC;
        end else if (iREN) begin
          state_d = ARB_IACC;
        end
      end
      ARB_IACC, ARB_DACC: begin
        if (ram_ack || wdog_expire) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ihit     = (state_q == ARB_IACC) && ram_ack && !abort_q && !fetch_stale;
    dhit     = (state_q == ARB_DACC) && ram_ack;
    iload    = ihit ? ramload : '0;
    dload    = dhit ? ramload : '0;
    ramREN   = (state_q == ARB_IACC) || ((state_q == ARB_DACC) && !wen_q);
    ramWEN   = (state_q == ARB_DACC) && wen_q;
    ramaddr  = busy ? addr_q : '0;
    ramstore = busy ? store_q : '0;
    ram_err  = err_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q   <= '0;
      store_q  <= '0;
      wen_q    <= 1'b0;
      abort_q  <= 1'b0;
      streak_q <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (!busy && (state_d == ARB_DACC)) begin
        addr_q  <= daddr;
        store_q <= dstore;
        wen_q   <= dWEN;
      end else if (!busy && (state_d == ARB_IACC)) begin
        addr_q  <= iaddr;
        store_q <= '0;
        wen_q   <= 1'b0;
      end

      if (!busy) begin
        abort_q <= 1'b0;
      end else if (state_q == ARB_IACC) begin
        abort_q <= abort_q | fetch_stale;
      end

      wdog_q <= busy ? wdog_q + WW'(1) : '0;

      if (wdog_expire) begin
        err_q <= 1'b1;
      end

      if (!iREN || ihit) begin
        streak_q <= '0;
      end else if (dhit && (streak_q < SW'(MAX_DSTREAK))) begin
        streak_q <= streak_q + SW'(1);
      end
    end
  end

endmodule
